sync_data_memory: RTL



---
 rtl/sync_data_memory_if.sv | 38 +++
 rtl/sync_data_memory.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sync_data_memory_if.sv
// ---------------------------------------------------------------------------
// sync_data_memory_if
//
// Bus bundle between the load/store unit (master) and sync_data_memory
// (slave).
//
// Signals:
//   re, raddr     read request, sampled on the rising clock edge
//   rdata, rvalid registered read data, and its one-cycle qualifier
//   we, waddr,    write request, sampled on the rising clock edge
//   wdata
//   busy          clear sweep in progress; requests are ignored
//   oob           one-cycle pulse flagging an out-of-range access
// ---------------------------------------------------------------------------
interface sync_data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              oob;

  modport master (
    output re, raddr, we, waddr, wdata,
    input  rdata, rvalid, busy, oob
  );

  modport slave (
    input  re, raddr, we, waddr, wdata,
    output rdata, rvalid, busy, oob
  );
endinterface

// File: rtl/sync_data_memory.sv
// ---------------------------------------------------------------------------
// sync_data_memory
//
// Parametrised synchronous data memory for the SimpleCPU datapath. It has one
// write port and one registered read port. After every reset, a hardware
// sweep writes INIT_VAL into every word. Accesses addressed at or beyond
// DEPTH are flagged on oob.
//
// Parameters:
//   DATA_W    data word width in bits
//   ADDR_W    address width in bits
//   DEPTH     number of words, 1 <= DEPTH <= 2**ADDR_W
//   INIT_VAL  value written to every word by the clear sweep
//
// Ports:
//   clk   clock; all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   sync_data_memory_if.slave (re/raddr/rdata/rvalid,
//         we/waddr/wdata, busy, oob)
//
// Build option:
//   SYNC_DMEM_BYPASS_EN  defined   : a same-cycle read and write to the same
//                                    in-range address returns wdata
//                                    (write-first).
//                        undefined : the same case returns the old contents
//                                    (read-first). The write still completes.
// ---------------------------------------------------------------------------
module sync_data_memory #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  sync_data_memory_if.slave   bus
);

  localparam int                CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  clr_cnt, clr_cnt_next;

  logic              mem_we;
  logic [CNT_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_fire;
  logic              oob_next;

  logic              rd_in_range;
  logic              wr_in_range;
  logic              byp_hit;
  logic [CNT_W-1:0]  rd_idx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              oob_q;

  // Zero-extend the addresses so that DEPTH == 2**ADDR_W still compares
  // correctly.
  assign rd_in_range = ({1'b0, bus.raddr} < DEPTH_X);
  assign wr_in_range = ({1'b0, bus.waddr} < DEPTH_X);
  assign rd_idx      = bus.raddr[CNT_W-1:0];

`ifdef SYNC_DMEM_BYPASS_EN
  // Write-first: a read that collides with this cycle's write sees wdata.
  assign byp_hit = bus.we && wr_in_range && rd_in_range &&
                   (bus.waddr == bus.raddr);
`else
  // Read-first: a colliding read returns the array's pre-write contents.
  assign byp_hit = 1'b0;
`endif

  // State register. A reset always restarts the sweep from word 0, even
  // when it arrives in the middle of a sweep.
  // NOTE: sequential state uses non-blocking (<=) so that every register
  // samples the values from before the edge; blocking here would create
  // order-dependent races between always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Next-state logic and array-port steering.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    mem_we       = 1'b0;
    mem_addr     = bus.waddr[CNT_W-1:0];
    mem_wdata    = bus.wdata;
    rd_fire      = 1'b0;
    oob_next     = 1'b0;

    unique case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt;
        mem_wdata = INIT_VAL;
        // Hold the counter at the last word so that it never wraps.
        if (clr_cnt == LAST) state_next   = READY;
        else                 clr_cnt_next = clr_cnt + 1'b1;
      end
      READY: begin
        mem_we   = bus.we && wr_in_range;
        rd_fire  = bus.re;
        // An out-of-range read and an out-of-range write in the same cycle
        // produce one pulse, not two.
        oob_next = (bus.re && !rd_in_range) || (bus.we && !wr_in_range);
      end
      default: state_next = CLEAR;
    endcase
  end

  // Storage array. The sweep writes INIT_VAL into every word, so the array
  // needs no reset of its own. The write is suppressed on the reset edge
  // itself.
  // NOTE: the array is deliberately left out of reset; a reset on every word
  // would prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Registered read port and status flags. rdata holds its value whenever
  // no read fires, including throughout the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_fire;
      oob_q    <= oob_next;
      if (rd_fire) begin
        if (!rd_in_range) rdata_q <= INIT_VAL;
        else if (byp_hit) rdata_q <= bus.wdata;
        else              rdata_q <= mem[rd_idx];
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.oob    = oob_q;
  assign bus.busy   = (state == CLEAR);

endmodule
